// File: rtl/mk14_keypad.sv
// MK14 keypad front end: synchronises and debounces 20 raw keys and turns level
// changes into press/release events addressed by keyboard-matrix row and bit.
module mk14_keypad #(
  parameter int CLOCK_FREQ_MHZ = 50,
  parameter int DEBOUNCE_US    = 1000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] keys_raw,
  output logic [19:0] key_state,
  output logic        kbd_write_en,
  output logic [2:0]  kbd_addr,
  output logic [2:0]  kbd_bit,
  output logic        kbd_pressed,
  output logic        busy
);

  localparam int TICKS = CLOCK_FREQ_MHZ * DEBOUNCE_US;
  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS - 1);
  localparam logic [4:0] LAST_KEY = 5'd19;

  typedef enum logic {INIT, RUN} state_t;

  logic [19:0]      sync1_reg, sync2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             tick;
  logic [19:0]      debounced;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= keys_raw;
      sync2_reg <= sync1_reg;
      cnt_reg   <= tick ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  assign tick = (cnt_reg == CNT_MAX);

  // Each key keeps its own sample history; its debounced level moves only on a unanimous history.
  genvar gi;
  generate
    for (gi = 0; gi < 20; gi++) begin : g_key
      logic [STABLE_SAMPLES-1:0] hist_reg;
      logic                      level_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hist_reg  <= '0;
          level_reg <= 1'b0;
        end else begin
          if (tick)
            hist_reg <= {hist_reg[STABLE_SAMPLES-2:0], sync2_reg[gi]};
          if (&hist_reg)
            level_reg <= 1'b1;
          else if (hist_reg == '0)
            level_reg <= 1'b0;
        end
      end

      assign debounced[gi] = level_reg;
    end
  endgenerate

  assign key_state = debounced;

  // Returns {row address, bit} of a key in the MK14 matrix.
  function automatic logic [5:0] key_map(input logic [4:0] k);
    logic [5:0] m;
    m = 6'd0;
    if (k < 5'd8)
      m = {k[2:0], 3'd7};
    else if (k < 5'd10)
      m = {2'b00, k[0], 3'd6};
    else begin
      case (k)
        5'd10:   m = {3'd0, 3'd4};
        5'd11:   m = {3'd1, 3'd4};
        5'd12:   m = {3'd3, 3'd4};
        5'd13:   m = {3'd4, 3'd4};
        5'd14:   m = {3'd6, 3'd4};
        5'd15:   m = {3'd7, 3'd4};
        5'd16:   m = {3'd2, 3'd5};
        5'd17:   m = {3'd3, 3'd5};
        5'd18:   m = {3'd4, 3'd5};
        5'd19:   m = {3'd7, 3'd5};
        default: m = 6'd0;
      endcase
    end
    return m;
  endfunction

  state_t      state_reg, state_next;
  logic [4:0]  ptr_reg, ptr_next;
  logic [19:0] reported_reg, reported_next;
  logic        we_reg, we_next;
  logic [2:0]  addr_reg, addr_next;
  logic [2:0]  bit_reg, bit_next;
  logic        pressed_reg, pressed_next;
  logic        busy_reg, busy_next;
  logic [5:0]  ptr_map;

  assign ptr_map = key_map(ptr_reg);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = (ptr_reg == LAST_KEY) ? 5'd0 : ptr_reg + 5'd1;
    reported_next = reported_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    bit_next      = bit_reg;
    pressed_next  = pressed_reg;
    // Registered one cycle late so busy covers the final replay strobe.
    busy_next     = (state_reg == INIT);
    case (state_reg)
      INIT: begin
        we_next      = 1'b1;
        pressed_next = 1'b0;
        addr_next    = ptr_map[5:3];
        bit_next     = ptr_map[2:0];
        if (ptr_reg == LAST_KEY)
          state_next = RUN;
      end
      RUN: begin
        if (debounced[ptr_reg] != reported_reg[ptr_reg]) begin
          we_next                = 1'b1;
          pressed_next           = debounced[ptr_reg];
          addr_next              = ptr_map[5:3];
          bit_next               = ptr_map[2:0];
          reported_next[ptr_reg] = debounced[ptr_reg];
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= INIT;
      ptr_reg      <= 5'd0;
      reported_reg <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= 3'd0;
      bit_reg      <= 3'd0;
      pressed_reg  <= 1'b0;
      busy_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      reported_reg <= reported_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      bit_reg      <= bit_next;
      pressed_reg  <= pressed_next;
      busy_reg     <= busy_next;
    end
  end

  assign kbd_write_en = we_reg;
  assign kbd_addr     = addr_reg;
  assign kbd_bit      = bit_reg;
  assign kbd_pressed  = pressed_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_mk14_keypad.sv
// Directed bench for mk14_keypad: reset replay, press/release, glitch rejection,
// simultaneous keys, reset with a held key and the default tick period.
module tb_mk14_keypad;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [19:0] keys_raw = '0;
  logic [19:0] key_state;
  logic        kbd_write_en, kbd_pressed, busy;
  logic [2:0]  kbd_addr, kbd_bit;

  logic        rst2_n = 1'b0;
  logic [19:0] keys2 = '0;
  logic [19:0] key_state2;
  logic        we2, pressed2, busy2;
  logic [2:0]  addr2, bit2;

  mk14_keypad #(.CLOCK_FREQ_MHZ(1), .DEBOUNCE_US(2), .STABLE_SAMPLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .keys_raw(keys_raw), .key_state(key_state),
    .kbd_write_en(kbd_write_en), .kbd_addr(kbd_addr), .kbd_bit(kbd_bit),
    .kbd_pressed(kbd_pressed), .busy(busy)
  );

  mk14_keypad dut2 (
    .clk(clk), .rst_n(rst2_n), .keys_raw(keys2), .key_state(key_state2),
    .kbd_write_en(we2), .kbd_addr(addr2), .kbd_bit(bit2),
    .kbd_pressed(pressed2), .busy(busy2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int check_cnt = 0;
  int run_base = 0;  // edge number at which the scan first examines key 0 in RUN

  logic [2:0] exp_addr [20] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1,
                                3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd7, 3'd2, 3'd3, 3'd4, 3'd7};
  logic [2:0] exp_bit  [20] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd6,
                                3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5};

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // First edge after edge n at which the scan reaches key k.
  function automatic int exp_edge(input int k, input int n);
    int ph;
    ph = (n + 1 - run_base) % 20;
    return n + 1 + ((k - ph + 20) % 20);
  endfunction

  task automatic test_reset(input logic [19:0] held);
    int strobes;
    keys_raw = held;
    rst_n = 1'b0;
    next_cycle();
    check_cnt++;
    if ({kbd_write_en, kbd_addr, kbd_bit, kbd_pressed, busy, key_state} !==
        {1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 20'd0})
      $display("FAIL reset_state: got we=%0b addr=%0d bit=%0d pr=%0b busy=%0b ks=%h, want 0 0 0 0 1 00000",
               kbd_write_en, kbd_addr, kbd_bit, kbd_pressed, busy, key_state);
    else pass_cnt++;
    run_base = cyc + 21;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      check_cnt++;
      if (kbd_write_en !== 1'b1 || kbd_pressed !== 1'b0 || busy !== 1'b1 ||
          kbd_addr !== exp_addr[i] || kbd_bit !== exp_bit[i])
        $display("FAIL replay_%0d: got we=%0b pr=%0b busy=%0b (%0d,%0d), want 1 0 1 (%0d,%0d)",
                 i, kbd_write_en, kbd_pressed, busy, kbd_addr, kbd_bit, exp_addr[i], exp_bit[i]);
      else pass_cnt++;
    end
    next_cycle();
    check_cnt++;
    if (busy !== 1'b0 || kbd_write_en !== 1'b0)
      $display("FAIL busy_fall: got busy=%0b we=%0b, want 0 0", busy, kbd_write_en);
    else pass_cnt++;
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (kbd_write_en === 1'b1) strobes++;
    end
    check_cnt++;
    if (strobes != 0) $display("FAIL after_replay_quiet: got %0d strobes, want 0", strobes);
    else pass_cnt++;
    $display("reset replay done at cycle %0d", cyc);
  endtask

  task automatic test_press_release();
    int n, e, cnt, got_cyc;
    logic [2:0] a, b;
    logic p, lvl;
    for (int ph = 0; ph < 2; ph++) begin
      lvl = (ph == 0);
      keys_raw[5] = lvl;
      n = -1;
      for (int i = 0; i < 10; i++) begin
        next_cycle();
        if (key_state[5] === lvl) begin n = cyc; break; end
      end
      check_cnt++;
      if (n < 0) begin
        $display("FAIL debounce_k5_%0d: key_state[5]=%0b after 10 cycles, want %0b", ph, key_state[5], lvl);
        n = cyc;
      end else pass_cnt++;
      e = exp_edge(5, n);
      cnt = 0; got_cyc = -1; a = 3'd0; b = 3'd0; p = 1'b0;
      for (int i = 0; i < 25; i++) begin
        next_cycle();
        if (kbd_write_en === 1'b1) begin
          cnt++; got_cyc = cyc; a = kbd_addr; b = kbd_bit; p = kbd_pressed;
        end
      end
      check_cnt++;
      if (cnt != 1 || got_cyc != e || a !== 3'd5 || b !== 3'd7 || p !== lvl)
        $display("FAIL event_k5_%0d: got n=%0d cyc=%0d (%0d,%0d,%0b), want n=1 cyc=%0d (5,7,%0b)",
                 ph, cnt, got_cyc, a, b, p, e, lvl);
      else pass_cnt++;
      $display("key5 %s event at cycle %0d", lvl ? "press" : "release", got_cyc);
    end
  endtask

  task automatic test_glitch();
    int strobes, seen;
    strobes = 0; seen = 0;
    keys_raw[16] = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (i == 3) keys_raw[16] = 1'b0;
      next_cycle();
      if (kbd_write_en === 1'b1) strobes++;
      if (key_state[16] !== 1'b0) seen++;
    end
    check_cnt++;
    if (seen != 0) $display("FAIL glitch_state: key_state[16] high %0d cycles, want 0", seen);
    else pass_cnt++;
    check_cnt++;
    if (strobes != 0) $display("FAIL glitch_event: got %0d strobes, want 0", strobes);
    else pass_cnt++;
    $display("glitch on GO: %0d strobes", strobes);
  endtask

  task automatic test_simultaneous();
    int n, e12, e18, cnt;
    int gc [2];
    logic [2:0] ga [2];
    logic [2:0] gb [2];
    logic gp [2];
    int ec0, ec1;
    logic [2:0] ea0, eb0, ea1, eb1;
    keys_raw[12] = 1'b1;
    keys_raw[18] = 1'b1;
    n = -1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (key_state[12] === 1'b1 || key_state[18] === 1'b1) begin n = cyc; break; end
    end
    check_cnt++;
    if (n < 0 || key_state[12] !== 1'b1 || key_state[18] !== 1'b1) begin
      $display("FAIL simul_debounce: key_state[12]=%0b [18]=%0b, want 1 1 together", key_state[12], key_state[18]);
      n = cyc;
    end else pass_cnt++;
    e12 = exp_edge(12, n);
    e18 = exp_edge(18, n);
    if (e12 < e18) begin
      ec0 = e12; ea0 = 3'd3; eb0 = 3'd4; ec1 = e18; ea1 = 3'd4; eb1 = 3'd5;
    end else begin
      ec0 = e18; ea0 = 3'd4; eb0 = 3'd5; ec1 = e12; ea1 = 3'd3; eb1 = 3'd4;
    end
    cnt = 0;
    for (int i = 0; i < 2; i++) begin gc[i] = -1; ga[i] = 3'd0; gb[i] = 3'd0; gp[i] = 1'b0; end
    for (int i = 0; i < 25; i++) begin
      next_cycle();
      if (kbd_write_en === 1'b1) begin
        if (cnt < 2) begin gc[cnt] = cyc; ga[cnt] = kbd_addr; gb[cnt] = kbd_bit; gp[cnt] = kbd_pressed; end
        cnt++;
      end
    end
    check_cnt++;
    if (cnt != 2) $display("FAIL simul_count: got %0d strobes, want 2", cnt);
    else pass_cnt++;
    check_cnt++;
    if (gc[0] != ec0 || ga[0] !== ea0 || gb[0] !== eb0 || gp[0] !== 1'b1)
      $display("FAIL simul_first: got cyc=%0d (%0d,%0d,%0b), want cyc=%0d (%0d,%0d,1)",
               gc[0], ga[0], gb[0], gp[0], ec0, ea0, eb0);
    else pass_cnt++;
    check_cnt++;
    if (gc[1] != ec1 || ga[1] !== ea1 || gb[1] !== eb1 || gp[1] !== 1'b1)
      $display("FAIL simul_second: got cyc=%0d (%0d,%0d,%0b), want cyc=%0d (%0d,%0d,1)",
               gc[1], ga[1], gb[1], gp[1], ec1, ea1, eb1);
    else pass_cnt++;
    $display("simultaneous C+ABORT events at cycles %0d and %0d", gc[0], gc[1]);
    keys_raw[12] = 1'b0;
    keys_raw[18] = 1'b0;
    for (int i = 0; i < 40; i++) next_cycle();
  endtask

  task automatic test_hold_reset();
    int n, cnt, got_cyc, e;
    logic [2:0] a, b;
    logic p;
    keys_raw[9] = 1'b1;
    n = -1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (key_state[9] === 1'b1) begin n = cyc; break; end
    end
    if (n < 0) n = cyc;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      next_cycle();
      if (kbd_write_en === 1'b1) cnt++;
    end
    check_cnt++;
    if (cnt != 1) $display("FAIL hold_pre_press: got %0d strobes, want 1", cnt);
    else pass_cnt++;
    test_reset(20'h00200);
    check_cnt++;
    if (key_state[9] !== 1'b1) $display("FAIL hold_debounce: key_state[9]=%0b, want 1", key_state[9]);
    else pass_cnt++;
    e = run_base + 9;
    cnt = 0; got_cyc = -1; a = 3'd0; b = 3'd0; p = 1'b0;
    for (int i = 0; i < 25; i++) begin
      next_cycle();
      if (kbd_write_en === 1'b1) begin
        cnt++; got_cyc = cyc; a = kbd_addr; b = kbd_bit; p = kbd_pressed;
      end
    end
    check_cnt++;
    if (cnt != 1 || got_cyc != e || a !== 3'd1 || b !== 3'd6 || p !== 1'b1)
      $display("FAIL hold_press: got n=%0d cyc=%0d (%0d,%0d,%0b), want n=1 cyc=%0d (1,6,1)",
               cnt, got_cyc, a, b, p, e);
    else pass_cnt++;
    $display("held key9 press after reset at cycle %0d", got_cyc);
    keys_raw[9] = 1'b0;
    for (int i = 0; i < 30; i++) next_cycle();
  endtask

  task automatic test_tick_period();
    int first;
    logic t1, t2;
    first = -1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (dut.tick === 1'b1) begin first = i; break; end
    end
    next_cycle(); t1 = dut.tick;
    next_cycle(); t2 = dut.tick;
    check_cnt++;
    if (first < 0 || t1 !== 1'b0 || t2 !== 1'b1)
      $display("FAIL tick_small: got seen=%0d next=%0b then=%0b, want seen>=0 0 1", first, t1, t2);
    else pass_cnt++;
    // The cycle right after the last reset edge holds count 0 and is cycle 1 of the period.
    rst2_n = 1'b1;
    first = -1;
    for (int i = 2; i <= 50003; i++) begin
      next_cycle();
      if (dut2.tick === 1'b1 && first < 0) first = i;
    end
    check_cnt++;
    if (first != 50000)
      $display("FAIL tick_period_default: tick in cycle %0d of the period, want 50000", first);
    else pass_cnt++;
    $display("default tick period measured: %0d cycles", first);
  endtask

  initial begin
    test_reset(20'h00000);
    test_press_release();
    test_glitch();
    test_simultaneous();
    test_hold_reset();
    test_tick_period();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
